conv_4_ctrl: RTL and testbench

- Sequencer for one 4x4 convolution engine (mulfp16 products into an addfp16 tree, registered result, then an output register gated by valid_out).
- Pulls kernel rows and then image rows from an upstream row source using a valid/ready handshake.
- Drives the engine's valid_in, kernel_load and valid_out.
- Emits an aligned out_valid strobe plus output-row index to the downstream writer, and signals strip completion.

---
 rtl/conv_4_ctrl.sv | 155 +++++++++++++++
 tb/tb_conv_4_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/conv_4_ctrl.sv
// Strip sequencer for the 4x4 convolution engine: kernel rows first, then image rows,
// with a 3-deep valid/index pipe that lines out_valid up with the engine result register.
module conv_4_ctrl #(
   parameter int KERNEL_SIZE = 4,
   parameter int IMG_ROWS    = 28,
   parameter int ROW_W       = $clog2(IMG_ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             reload_kernel,
   input  logic             row_valid,
   output logic             row_ready,
   output logic             conv_valid_in,
   output logic             conv_kernel_load,
   output logic             conv_valid_out,
   output logic             out_valid,
   output logic [ROW_W-1:0] out_row_idx,
   output logic             busy,
   output logic             done,
   output logic             kernel_loaded
);

   localparam int               KC_W      = $clog2(KERNEL_SIZE);
   localparam logic [KC_W-1:0]  K_LAST    = KC_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0] WIN_FIRST = ROW_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_K = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [KC_W-1:0]  krow_cnt_q, krow_cnt_d;
   logic [ROW_W-1:0] irow_cnt_q, irow_cnt_d;
   logic [2:0]       pipe_vld_q, pipe_vld_d;
   logic [ROW_W-1:0] tag0_q, tag0_d;
   logic [ROW_W-1:0] tag1_q, tag1_d;
   logic [ROW_W-1:0] tag2_q, tag2_d;
   logic             kloaded_q, kloaded_d;
   logic             row_ready_q, row_ready_d;
   logic             kload_q, kload_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             xfer;

   assign xfer = row_valid && row_ready_q;

   always_comb begin
      state_d    = state_q;
      krow_cnt_d = krow_cnt_q;
      irow_cnt_d = irow_cnt_q;
      kloaded_d  = kloaded_q;
      // The pipe shifts every cycle so upstream stalls only open gaps.
      pipe_vld_d = {pipe_vld_q[1:0], 1'b0};
      tag0_d     = tag0_q;
      tag1_d     = tag0_q;
      tag2_d     = tag1_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (reload_kernel || !kloaded_q) ? LOAD_K : STREAM;
            end
         end
         LOAD_K: begin
            if (xfer) begin
               if (krow_cnt_q == K_LAST) begin
                  krow_cnt_d = '0;
                  kloaded_d  = 1'b1;
                  state_d    = STREAM;
               end else begin
                  krow_cnt_d = krow_cnt_q + 1'b1;
               end
            end
         end
         STREAM: begin
            if (xfer) begin
               // Only rows of this strip count toward a window; stale buffer rows never do.
               if (irow_cnt_q >= WIN_FIRST) begin
                  pipe_vld_d[0] = 1'b1;
                  tag0_d        = irow_cnt_q - WIN_FIRST;
               end
               if (irow_cnt_q == ROW_LAST) begin
                  irow_cnt_d = '0;
                  state_d    = DRAIN;
               end else begin
                  irow_cnt_d = irow_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (pipe_vld_q[1:0] == 2'b00) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      row_ready_d = (state_d == LOAD_K) || (state_d == STREAM);
      kload_d     = (state_d == LOAD_K);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         krow_cnt_q  <= '0;
         irow_cnt_q  <= '0;
         pipe_vld_q  <= '0;
         tag0_q      <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         kloaded_q   <= 1'b0;
         row_ready_q <= 1'b0;
         kload_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         krow_cnt_q  <= krow_cnt_d;
         irow_cnt_q  <= irow_cnt_d;
         pipe_vld_q  <= pipe_vld_d;
         tag0_q      <= tag0_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
         kloaded_q   <= kloaded_d;
         row_ready_q <= row_ready_d;
         kload_q     <= kload_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign row_ready        = row_ready_q;
   assign conv_valid_in    = xfer;
   assign conv_kernel_load = kload_q;
   assign conv_valid_out   = pipe_vld_q[1];
   assign out_valid        = pipe_vld_q[2];
   assign out_row_idx      = tag2_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign kernel_loaded    = kloaded_q;

endmodule

// File: tb/tb_conv_4_ctrl.sv
// Randomized bench for conv_4_ctrl: a transfer-level model predicts handshakes and
// pushes expected results into queues that a negedge monitor pops and compares.
module tb_conv_4_ctrl;
   localparam int K    = 4;
   localparam int ROWS = 28;
   localparam int RW   = $clog2(ROWS);
   localparam int NOUT = ROWS - K + 1;

   logic          clk = 1'b0;
   logic          rst, start, reload_kernel, row_valid;
   logic          row_ready, conv_valid_in, conv_kernel_load, conv_valid_out, out_valid;
   logic [RW-1:0] out_row_idx;
   logic          busy, done, kernel_loaded;

   conv_4_ctrl #(.KERNEL_SIZE(K), .IMG_ROWS(ROWS)) dut (
      .clk(clk), .rst(rst), .start(start), .reload_kernel(reload_kernel),
      .row_valid(row_valid), .row_ready(row_ready), .conv_valid_in(conv_valid_in),
      .conv_kernel_load(conv_kernel_load), .conv_valid_out(conv_valid_out),
      .out_valid(out_valid), .out_row_idx(out_row_idx), .busy(busy), .done(done),
      .kernel_loaded(kernel_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int idx; } exp_t;
   exp_t ov_q[$];
   int   cvo_q[$];

   int checks = 0, errors = 0;

   // Reference model state: written only by the monitor.
   bit m_busy, m_clr, m_st_pend, m_kloaded, m_kl_pend;
   int m_nk, m_xfers, m_outs, m_last_out, m_bcyc;
   bit e_rdy, e_kl, e_xfer, e_cvo, e_ov, e_done;
   exp_t e;

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_outputs_zero",
             int'({row_ready, conv_valid_in, conv_kernel_load, conv_valid_out,
                   out_valid, busy, done, kernel_loaded, out_row_idx}), 0);
         m_busy = 0; m_clr = 0; m_st_pend = 0; m_kloaded = 0; m_kl_pend = 0;
         m_nk = 0; m_xfers = 0; m_outs = 0; m_bcyc = 0; m_last_out = -10;
         ov_q.delete();
         cvo_q.delete();
      end else begin
         if (m_clr) begin m_busy = 0; m_clr = 0; end
         if (m_kl_pend) begin m_kloaded = 1; m_kl_pend = 0; end
         if (m_st_pend) begin m_busy = 1; m_st_pend = 0; m_bcyc = 0; end

         e_rdy  = m_busy && (m_xfers < m_nk + ROWS);
         e_kl   = m_busy && (m_xfers < m_nk);
         e_xfer = row_valid && e_rdy;
         chk("row_ready", row_ready, e_rdy);
         chk("conv_kernel_load", conv_kernel_load, e_kl);
         chk("conv_valid_in", conv_valid_in, e_xfer);
         chk("busy", busy, m_busy);
         chk("kernel_loaded", kernel_loaded, m_kloaded);

         while (cvo_q.size() > 0 && cvo_q[0] < cyc) void'(cvo_q.pop_front());
         e_cvo = (cvo_q.size() > 0) && (cvo_q[0] == cyc);
         chk("conv_valid_out", conv_valid_out, e_cvo);
         if (e_cvo) void'(cvo_q.pop_front());

         while (ov_q.size() > 0 && ov_q[0].cyc < cyc) void'(ov_q.pop_front());
         e_ov = (ov_q.size() > 0) && (ov_q[0].cyc == cyc);
         chk("out_valid", out_valid, e_ov);
         if (e_ov) begin
            chk("out_row_idx", out_row_idx, ov_q[0].idx);
            if (ov_q[0].idx == NOUT - 1) m_last_out = cyc;
            void'(ov_q.pop_front());
            m_outs++;
         end

         e_done = m_busy && (m_outs == NOUT) && (cyc == m_last_out + 1);
         chk("done", done, e_done);
         if (e_done) begin
            chk("strip_transfers", m_xfers, m_nk + ROWS);
            m_clr = 1;
         end

         if (e_xfer) begin
            if (m_xfers < m_nk) begin
               if (m_xfers == m_nk - 1) m_kl_pend = 1;
            end else if (m_xfers - m_nk >= K - 1) begin
               e.cyc = cyc + 3;
               e.idx = m_xfers - m_nk - (K - 1);
               ov_q.push_back(e);
               cvo_q.push_back(cyc + 2);
            end
            m_xfers++;
         end

         // A start is honoured only from idle; anywhere else it must be ignored.
         if (start && !m_busy && !m_st_pend) begin
            m_st_pend = 1;
            m_nk      = (reload_kernel || !m_kloaded) ? K : 0;
            m_xfers   = 0;
            m_outs    = 0;
            m_last_out = -10;
         end

         if (m_busy) begin
            m_bcyc++;
            if (m_bcyc == 400) chk("strip_overrun_cycles", m_bcyc, 0);
         end
      end
   end

   function automatic logic pat(input int mode, input int i);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((i % 4) == 0) || ((i % 4) == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_strip(input bit rl, input int mode, input bit ign);
      int i;
      bit dp;
      dp = 0;
      @(posedge clk); #1;
      start = 1; reload_kernel = rl; row_valid = pat(mode, 0);
      @(posedge clk); #1;
      start = 0; reload_kernel = 0;
      i = 1;
      while ((m_busy || m_st_pend) && i < 500) begin
         row_valid = pat(mode, i);
         start = 0;
         if (ign && i == 10) start = 1;
         if (ign && !dp && m_busy && m_xfers == m_nk + ROWS) begin
            start = 1;
            dp = 1;
         end
         @(posedge clk); #1;
         i++;
      end
      start = 0; row_valid = 0;
   endtask

   task automatic abort_strip();
      int g;
      g = 0;
      @(posedge clk); #1;
      start = 1; reload_kernel = 1; row_valid = 1;
      @(posedge clk); #1;
      start = 0; reload_kernel = 0;
      while (!(m_busy && m_xfers == m_nk + 10) && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0; row_valid = 0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst = 1; start = 0; reload_kernel = 0; row_valid = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      repeat (2) @(posedge clk);
      run_strip(1'b0, 0, 1'b0);   // empty kernel forces a load
      run_strip(1'b0, 0, 1'b0);   // kernel reuse
      run_strip(1'b1, 0, 1'b0);   // explicit reload
      run_strip(1'b0, 1, 1'b0);   // 1,0,0,1 upstream stalls
      run_strip(1'b0, 0, 1'b1);   // starts during STREAM and DRAIN are ignored
      abort_strip();
      run_strip(1'b0, 0, 1'b0);   // kernel lost to reset, load again
      for (int n = 0; n < 6; n++) run_strip(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
